// File: rtl/mem_arb_if.sv
// Bus bundle between the two pipeline memory lanes, the arbiter and the
// single-port synchronous memory.
interface mem_arb_if;
  // lane requests and payloads
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [4:0]  rd0;
  logic [4:0]  rd1;

  // lane responses
  logic        ack0;
  logic        ack1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic [4:0]  wa0;
  logic [4:0]  wa1;
  logic        stall;

  // memory port
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rd0, rd1,
    input  mem_rdata,
    output ack0, ack1, rdata0, rdata1, wa0, wa1, stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rd0, rd1,
    output mem_rdata,
    input  ack0, ack1, rdata0, rdata1, wa0, wa1, stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb.sv
// Two-lane memory arbiter onto one synchronous single-port memory; lane 0 has
// fixed priority. Define MEM_ARB_FWD_EN to forward a lane-0 store to a same-address lane-1 load.
module mem_arb (
  input  logic       clk,
  input  logic       rst,
  mem_arb_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, ACC0, RSP0, ACC1, RSP1} state_t;

  state_t      state_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        ack0_q;
  logic        ack1_q;
  logic        rsp_we_q;
  logic [4:0]  rsp_rd_q;
  logic        fwd_q;
  logic [31:0] fwd_data_q;
  logic [4:0]  fwd_rd_q;
  logic        fwd_hit;

`ifdef MEM_ARB_FWD_EN
  assign fwd_hit = bus.req0 & bus.we0 & bus.req1 & ~bus.we1 &
                   (bus.addr0 == bus.addr1);
`else
  assign fwd_hit = 1'b0;
`endif

  // Response qualifiers are latched at issue so a requester dropping its
  // payload early cannot corrupt the reply of an access already started.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rd_q    <= 5'd0;
      fwd_q       <= 1'b0;
      fwd_data_q  <= 32'd0;
      fwd_rd_q    <= 5'd0;
    end else begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      mem_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req0) begin
            state_q     <= ACC0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.we0;
            mem_addr_q  <= bus.addr0;
            mem_wdata_q <= bus.wdata0;
            rsp_we_q    <= bus.we0;
            rsp_rd_q    <= bus.rd0;
            fwd_q       <= fwd_hit;
            fwd_data_q  <= bus.wdata0;
            fwd_rd_q    <= bus.rd1;
          end else if (bus.req1) begin
            state_q     <= ACC1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.we1;
            mem_addr_q  <= bus.addr1;
            mem_wdata_q <= bus.wdata1;
            rsp_we_q    <= bus.we1;
            rsp_rd_q    <= bus.rd1;
          end
        end
        ACC0: begin
          state_q <= RSP0;
          ack0_q  <= 1'b1;
          ack1_q  <= fwd_q;
        end
        RSP0: begin
          if (fwd_q) begin
            state_q <= IDLE;
            fwd_q   <= 1'b0;
          end else if (bus.req1) begin
            state_q     <= ACC1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.we1;
            mem_addr_q  <= bus.addr1;
            mem_wdata_q <= bus.wdata1;
            rsp_we_q    <= bus.we1;
            rsp_rd_q    <= bus.rd1;
          end else begin
            state_q <= IDLE;
          end
        end
        ACC1: begin
          state_q <= RSP1;
          ack1_q  <= 1'b1;
        end
        RSP1: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.stall     = (bus.req0 & ~ack0_q) | (bus.req1 & ~ack1_q);

  always_comb begin
    bus.rdata0 = 32'd0;
    bus.wa0    = 5'd0;
    bus.rdata1 = 32'd0;
    bus.wa1    = 5'd0;
    if (ack0_q && !rsp_we_q) begin
      bus.rdata0 = bus.mem_rdata;
      bus.wa0    = rsp_rd_q;
    end
    // A forwarded lane-1 load completes alongside the lane-0 store
    if (ack1_q && fwd_q) begin
      bus.rdata1 = fwd_data_q;
      bus.wa1    = fwd_rd_q;
    end else if (ack1_q && !rsp_we_q) begin
      bus.rdata1 = bus.mem_rdata;
      bus.wa1    = rsp_rd_q;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: a reference memory predicts load data, and
// expected memory strobes and acks are queued with the cycle they must appear.
module tb_mem_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if bus ();

  mem_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {int cyc; logic [31:0] data; logic [4:0] wa;} rsp_t;
  typedef struct {int cyc; logic we; logic [31:0] addr; logic [31:0] wdata;} acc_t;

  rsp_t sb0[$];
  rsp_t sb1[$];
  acc_t sba[$];
  bit   got0;
  bit   got1;

  // monitor: sample mid-cycle, compare against queued expectations
  initial begin
    bit   e0, e1, ea;
    rsp_t r;
    acc_t a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_ack0", {31'd0, bus.ack0}, 32'd0);
        chk("rst_ack1", {31'd0, bus.ack1}, 32'd0);
        chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
      end else begin
        e0 = (sb0.size() > 0) && (sb0[0].cyc == cyc);
        e1 = (sb1.size() > 0) && (sb1[0].cyc == cyc);
        ea = (sba.size() > 0) && (sba[0].cyc == cyc);
        chk("stall", {31'd0, bus.stall},
            {31'd0, (bus.req0 && !e0) || (bus.req1 && !e1)});
        chk("ack0", {31'd0, bus.ack0}, {31'd0, e0});
        chk("ack1", {31'd0, bus.ack1}, {31'd0, e1});
        if (e0) begin
          r = sb0.pop_front();
          chk("rdata0", bus.rdata0, r.data);
          chk("wa0", {27'd0, bus.wa0}, {27'd0, r.wa});
          got0 = 1'b1;
        end else begin
          chk("rdata0_idle", bus.rdata0, 32'd0);
          chk("wa0_idle", {27'd0, bus.wa0}, 32'd0);
        end
        if (e1) begin
          r = sb1.pop_front();
          chk("rdata1", bus.rdata1, r.data);
          chk("wa1", {27'd0, bus.wa1}, {27'd0, r.wa});
          got1 = 1'b1;
        end else begin
          chk("rdata1_idle", bus.rdata1, 32'd0);
          chk("wa1_idle", {27'd0, bus.wa1}, 32'd0);
        end
        chk("mem_en", {31'd0, bus.mem_en}, {31'd0, ea});
        if (ea) begin
          a = sba.pop_front();
          chk("mem_we", {31'd0, bus.mem_we}, {31'd0, a.we});
          chk("mem_addr", bus.mem_addr, a.addr);
          if (a.we) chk("mem_wdata", bus.mem_wdata, a.wdata);
        end
      end
    end
  end

  task automatic push_lane(input int lane, input int t, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [4:0] r);
    acc_t ac;
    rsp_t rs;
    ac.cyc = t + 1; ac.we = w; ac.addr = a; ac.wdata = d;
    sba.push_back(ac);
    rs.cyc  = t + 2;
    rs.data = w ? 32'd0 : ref_mem[a[7:0]];
    rs.wa   = w ? 5'd0 : r;
    if (w) ref_mem[a[7:0]] = d;
    if (lane == 0) sb0.push_back(rs);
    else           sb1.push_back(rs);
  endtask

  task automatic wait_acks(input bit v0, input bit v1, input bit late0, input int t);
    bit done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(posedge clk);
      #1;
      if (late0 && cyc == t + 1) bus.req0 = 1'b1;
      if (got0) bus.req0 = 1'b0;
      if (got1) bus.req1 = 1'b0;
      done = (!v0 || got0) && (!v1 || got1);
    end
    if (!done) chk("ack_timeout", 32'd0, 32'd1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the arbiter idle; late0 raises req0 one cycle
  // after req1 so it lands while lane 1 is already being served.
  task automatic run_txn(input bit v0, input logic w0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic [4:0] r0,
                         input bit v1, input logic w1, input logic [31:0] a1,
                         input logic [31:0] d1, input logic [4:0] r1,
                         input bit late0);
    int   t = cyc;
    bit   fwd = 1'b0;
    rsp_t rs;
`ifdef MEM_ARB_FWD_EN
    fwd = v0 && v1 && !late0 && w0 && !w1 && (a0 == a1);
`endif
    got0 = 1'b0;
    got1 = 1'b0;
    if (v0 && !late0) begin
      push_lane(0, t, w0, a0, d0, r0);
      if (v1 && fwd) begin
        rs.cyc = t + 2; rs.data = ref_mem[a1[7:0]]; rs.wa = r1;
        sb1.push_back(rs);
      end else if (v1) begin
        push_lane(1, t + 2, w1, a1, d1, r1);
      end
    end else begin
      if (v1) push_lane(1, t, w1, a1, d1, r1);
      if (v0) push_lane(0, t + 3, w0, a0, d0, r0);
    end
    bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0; bus.rd0 = r0;
    bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1; bus.rd1 = r1;
    bus.req0 = v0 && !late0;
    bus.req1 = v1;
    wait_acks(v0, v1, late0, t);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int mode;
    logic w0, w1;
    logic [31:0] a0, a1;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h1000 + i;
      ref_mem[i] = 32'h1000 + i;
    end
    mem[8'h10] = 32'hCAFE;
    ref_mem[8'h10] = 32'hCAFE;
    bus.mem_rdata = 32'd0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 32'd0; bus.addr1 = 32'd0; bus.wdata0 = 32'd0; bus.wdata1 = 32'd0;
    bus.rd0 = 5'd0; bus.rd1 = 5'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'd0);
    chk("reset_mem_wdata", bus.mem_wdata, 32'd0);
    chk("reset_stall", {31'd0, bus.stall}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // lone load
    run_txn(1, 0, 32'h10, 32'h0, 5'd8, 0, 0, 32'h0, 32'h0, 5'd0, 0);
    // store on lane 0 plus load on lane 1
    run_txn(1, 1, 32'h20, 32'h5, 5'd0, 1, 0, 32'h24, 32'h0, 5'd9, 0);
    // two stores to one address, lane 1 wins
    run_txn(1, 1, 32'h30, 32'h1, 5'd0, 1, 1, 32'h30, 32'h2, 5'd0, 0);
    chk("mem30_final", mem[8'h30], 32'h2);
    // store-to-load same address (forwarded or sequential)
    run_txn(1, 1, 32'h40, 32'h77, 5'd0, 1, 0, 32'h40, 32'h0, 5'd12, 0);
    // req0 arriving while lane 1 is in service waits for IDLE
    run_txn(1, 0, 32'h44, 32'h0, 5'd5, 1, 1, 32'h48, 32'hAB, 5'd0, 1);
    // full 32-bit address passes through
    run_txn(1, 0, 32'hFFFF_FF10, 32'h0, 5'd7, 0, 0, 32'h0, 32'h0, 5'd0, 0);

    // reset during ACC0 abandons the access
    got0 = 1'b0;
    bus.we0 = 1'b0; bus.addr0 = 32'h50; bus.rd0 = 5'd3; bus.req0 = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("async_rst_ack0", {31'd0, bus.ack0}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    t = cyc;
    push_lane(0, t, 1'b0, 32'h50, 32'h0, 5'd3);
    wait_acks(1, 0, 0, t);

    // randomized mix over a small address window to provoke conflicts
    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 2);
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      a0 = 32'h80 + 32'($urandom_range(0, 3) * 4);
      a1 = 32'h80 + 32'($urandom_range(0, 3) * 4);
      run_txn(mode != 1, w0, a0, $urandom, 5'($urandom_range(1, 31)),
              mode != 0, w1, a1, $urandom, 5'($urandom_range(1, 31)), 0);
    end
    if (sb0.size() != 0 || sb1.size() != 0 || sba.size() != 0)
      chk("scoreboard_drain", 32'd1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
